// File: rtl/fetch_pipe_ctrl_pkg.sv
// Shared types and constants for the fetch pipeline controller.
package fetch_pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_STALL = 2'd2
  } state_e;

  localparam logic [31:0] NOP_INSTR  = 32'h0000_0013;  // addi x0,x0,0
  localparam int unsigned CTRL_W_DEF = 8;
  localparam int unsigned PERF_W     = 32;

  // Bit positions inside the ID-stage control bundle
  localparam int unsigned CTRL_REGWRITE_BIT = 7;
  localparam int unsigned CTRL_MEMTOREG_BIT = 6;
  localparam int unsigned CTRL_MEMREAD_BIT  = 5;
  localparam int unsigned CTRL_MEMWRITE_BIT = 4;
  localparam int unsigned CTRL_ALUOP_HI_BIT = 3;
  localparam int unsigned CTRL_ALUOP_LO_BIT = 2;
  localparam int unsigned CTRL_ALUSRC_BIT   = 1;
  localparam int unsigned CTRL_BRANCH_BIT   = 0;

endpackage

// File: rtl/fetch_pipe_ctrl_if.sv
// Hazard handshake, fetch bus and pipeline-register outputs of fetch_pipe_ctrl.
// PERF_CNT_EN adds the performance counter outputs.
interface fetch_pipe_ctrl_if
  import fetch_pipe_ctrl_pkg::*;
#(
  parameter int unsigned CTRL_W = CTRL_W_DEF
) ();

  logic              start_i;
  logic              pc_write_i;
  logic              stall_i;
  logic              noop_i;
  logic              flush_i;
  logic [31:0]       branch_target_i;
  logic [31:0]       imem_instr_i;
  logic [CTRL_W-1:0] ctrl_id_i;
  logic [31:0]       pc_o;
  logic [31:0]       ifid_instr_o;
  logic [31:0]       ifid_pc_o;
  logic              ifid_valid_o;
  logic [CTRL_W-1:0] ctrl_ex_o;
  logic [1:0]        state_o;
  logic              stall_err_o;

`ifdef PERF_CNT_EN
  logic [PERF_W-1:0] stall_cycles_o;
  logic [PERF_W-1:0] flush_cnt_o;
  logic [PERF_W-1:0] bubble_cnt_o;

  modport master (
    output start_i, pc_write_i, stall_i, noop_i, flush_i, branch_target_i, imem_instr_i, ctrl_id_i,
    input  pc_o, ifid_instr_o, ifid_pc_o, ifid_valid_o, ctrl_ex_o, state_o, stall_err_o,
    input  stall_cycles_o, flush_cnt_o, bubble_cnt_o
  );
  modport slave (
    input  start_i, pc_write_i, stall_i, noop_i, flush_i, branch_target_i, imem_instr_i, ctrl_id_i,
    output pc_o, ifid_instr_o, ifid_pc_o, ifid_valid_o, ctrl_ex_o, state_o, stall_err_o,
    output stall_cycles_o, flush_cnt_o, bubble_cnt_o
  );
`else
  modport master (
    output start_i, pc_write_i, stall_i, noop_i, flush_i, branch_target_i, imem_instr_i, ctrl_id_i,
    input  pc_o, ifid_instr_o, ifid_pc_o, ifid_valid_o, ctrl_ex_o, state_o, stall_err_o
  );
  modport slave (
    input  start_i, pc_write_i, stall_i, noop_i, flush_i, branch_target_i, imem_instr_i, ctrl_id_i,
    output pc_o, ifid_instr_o, ifid_pc_o, ifid_valid_o, ctrl_ex_o, state_o, stall_err_o
  );
`endif

endinterface

// File: rtl/fetch_pipe_ctrl_pipe_reg.sv
// Pipeline register with clear (to reset value), load and hold.
module fetch_pipe_ctrl_pipe_reg #(
  parameter int unsigned    W       = 32,
  parameter logic [W-1:0]   RST_VAL = '0
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         clear_i,
  input  logic         load_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] data_q;

  // Clear beats load; neither means hold.
  always_ff @(posedge clk_i) begin
    if (!rst_i)       data_q <= RST_VAL;
    else if (clear_i) data_q <= RST_VAL;
    else if (load_i)  data_q <= d_i;
  end

  assign q_o = data_q;

endmodule

// File: rtl/fetch_pipe_ctrl.sv
// Fetch pipeline controller: PC, IF/ID and ID/EX control registers with
// hold/bubble/flush from the hazard unit and a bounded-stall watchdog.
// Optional: PERF_CNT_EN (performance counters), ASSERT_EN (sim-only checks).
module fetch_pipe_ctrl
  import fetch_pipe_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned CTRL_W    = CTRL_W_DEF,
  parameter int unsigned MAX_STALL = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  fetch_pipe_ctrl_if.slave bus
);

  localparam int unsigned     CNT_W   = $clog2(MAX_STALL + 2);
  localparam logic [CNT_W-1:0] CNT_SAT = CNT_W'(MAX_STALL + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_STALL);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic              stall_err_q, stall_err_d;
  logic [31:0]       pc_q, ifid_instr_q, ifid_pc_q;
  logic              ifid_valid_q;
  logic [CTRL_W-1:0] ctrl_ex_q;
  logic              upd_c, pc_load_c, flush_c, adv_c, bubble_c;
  logic [31:0]       pc_next_c;

  // Pipeline moves only in RUN/STALL with start held; a stall masks flush.
  assign upd_c     = (state_q != ST_IDLE) && bus.start_i;
  assign pc_load_c = upd_c && !bus.stall_i;
  assign flush_c   = pc_load_c && bus.flush_i;
  assign adv_c     = pc_load_c && !bus.flush_i;
  assign bubble_c  = bus.noop_i || bus.flush_i || !ifid_valid_q;
  assign pc_next_c = bus.flush_i ? bus.branch_target_i : pc_q + 32'd4;

  fetch_pipe_ctrl_pipe_reg #(.W(32), .RST_VAL(RESET_PC)) u_pc (
    .clk_i(clk_i), .rst_i(rst_i), .clear_i(1'b0), .load_i(pc_load_c),
    .d_i(pc_next_c), .q_o(pc_q)
  );

  fetch_pipe_ctrl_pipe_reg #(.W(32), .RST_VAL(NOP_INSTR)) u_ifid_instr (
    .clk_i(clk_i), .rst_i(rst_i), .clear_i(flush_c), .load_i(adv_c),
    .d_i(bus.imem_instr_i), .q_o(ifid_instr_q)
  );

  fetch_pipe_ctrl_pipe_reg #(.W(32), .RST_VAL(32'h0)) u_ifid_pc (
    .clk_i(clk_i), .rst_i(rst_i), .clear_i(flush_c), .load_i(adv_c),
    .d_i(pc_q), .q_o(ifid_pc_q)
  );

  fetch_pipe_ctrl_pipe_reg #(.W(1), .RST_VAL(1'b0)) u_ifid_valid (
    .clk_i(clk_i), .rst_i(rst_i), .clear_i(flush_c), .load_i(adv_c),
    .d_i(1'b1), .q_o(ifid_valid_q)
  );

  fetch_pipe_ctrl_pipe_reg #(.W(CTRL_W), .RST_VAL('0)) u_ctrl_ex (
    .clk_i(clk_i), .rst_i(rst_i), .clear_i(upd_c && bubble_c), .load_i(upd_c),
    .d_i(bus.ctrl_id_i), .q_o(ctrl_ex_q)
  );

  // Next state, stall-length counter and sticky stall error.
  always_comb begin
    state_d     = state_q;
    stall_cnt_d = stall_cnt_q;
    stall_err_d = stall_err_q;
    if (!bus.start_i) begin
      state_d     = ST_IDLE;
      stall_cnt_d = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: state_d = ST_RUN;
        ST_RUN, ST_STALL: begin
          if (bus.stall_i) begin
            state_d = ST_STALL;
            if (stall_cnt_q != CNT_SAT) stall_cnt_d = stall_cnt_q + CNT_W'(1);
          end else begin
            state_d     = ST_RUN;
            stall_cnt_d = '0;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
    if (stall_cnt_d > CNT_MAX) stall_err_d = 1'b1;
  end

  // FSM and watchdog registers.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q     <= ST_IDLE;
      stall_cnt_q <= '0;
      stall_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      stall_cnt_q <= stall_cnt_d;
      stall_err_q <= stall_err_d;
    end
  end

  assign bus.pc_o         = pc_q;
  assign bus.ifid_instr_o = ifid_instr_q;
  assign bus.ifid_pc_o    = ifid_pc_q;
  assign bus.ifid_valid_o = ifid_valid_q;
  assign bus.ctrl_ex_o    = ctrl_ex_q;
  assign bus.state_o      = state_q;
  assign bus.stall_err_o  = stall_err_q;

`ifdef PERF_CNT_EN
  logic [PERF_W-1:0] stall_cycles_q, flush_cnt_q, bubble_cnt_q;

  // Saturating event counters for stalls, taken flushes and HDU bubbles.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      stall_cycles_q <= '0;
      flush_cnt_q    <= '0;
      bubble_cnt_q   <= '0;
    end else begin
      if (upd_c && bus.stall_i && (stall_cycles_q != '1)) stall_cycles_q <= stall_cycles_q + PERF_W'(1);
      if (flush_c && (flush_cnt_q != '1))                 flush_cnt_q    <= flush_cnt_q + PERF_W'(1);
      if (upd_c && bus.noop_i && (bubble_cnt_q != '1))    bubble_cnt_q   <= bubble_cnt_q + PERF_W'(1);
    end
  end

  assign bus.stall_cycles_o = stall_cycles_q;
  assign bus.flush_cnt_o    = flush_cnt_q;
  assign bus.bubble_cnt_o   = bubble_cnt_q;
`endif

`ifdef ASSERT_EN
  // The HDU must never request a PC write while stalling; it is treated as a hold.
  always_ff @(posedge clk_i) begin
    if (rst_i && upd_c && bus.stall_i && bus.pc_write_i)
      $error("fetch_pipe_ctrl: pc_write_i asserted together with stall_i");
  end
`else
  // PC already holds on every stall, so pc_write_i carries no extra information.
  logic unused_pc_write;
  assign unused_pc_write = bus.pc_write_i;
`endif

endmodule

// File: tb/tb_fetch_pipe_ctrl.sv
// Self-checking bench for fetch_pipe_ctrl: reference model feeds a scoreboard.
module tb_fetch_pipe_ctrl;
  import fetch_pipe_ctrl_pkg::*;

  localparam int MAXS = 2;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] ipc;
    logic        v;
    logic [7:0]  ctrl;
    logic [1:0]  st;
    logic        err;
  } obs_t;

  logic clk_i = 1'b0;
  logic rst_i;

  fetch_pipe_ctrl_if #(.CTRL_W(8)) bus ();

  fetch_pipe_ctrl #(.RESET_PC(32'h0), .CTRL_W(8), .MAX_STALL(MAXS)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  always #5 clk_i = ~clk_i;

  // Combinational instruction memory: instruction = 0xA0 + address
  assign bus.imem_instr_i = 32'hA0 + bus.pc_o;

  obs_t        sb_q[$];
  obs_t        exp_o, got_o;
  int          n_cmp = 0;
  int          n_bad = 0;

  logic [31:0] m_pc, m_instr, m_ipc;
  logic        m_v, m_err;
  logic [7:0]  m_ctrl;
  logic [1:0]  m_st;
  int          m_cnt;

  function automatic obs_t sample();
    obs_t o;
    o.pc = bus.pc_o; o.instr = bus.ifid_instr_o; o.ipc = bus.ifid_pc_o;
    o.v = bus.ifid_valid_o; o.ctrl = bus.ctrl_ex_o; o.st = bus.state_o;
    o.err = bus.stall_err_o;
    return o;
  endfunction

  // Drive one cycle of stimulus, step the model, push the expectation, clock.
  task automatic drive_cycle(input logic rst, input logic start, input logic stall,
                             input logic noop, input logic flush,
                             input logic [31:0] tgt, input logic [7:0] cid);
    logic [7:0] nc;
    rst_i = rst; bus.start_i = start; bus.stall_i = stall; bus.pc_write_i = !stall;
    bus.noop_i = noop; bus.flush_i = flush; bus.branch_target_i = tgt; bus.ctrl_id_i = cid;
    if (!rst) begin
      m_pc = 32'h0; m_instr = 32'h13; m_ipc = 32'h0; m_v = 1'b0;
      m_ctrl = 8'h0; m_st = 2'd0; m_cnt = 0; m_err = 1'b0;
    end else if (!start) begin
      m_st = 2'd0; m_cnt = 0;
    end else if (m_st == 2'd0) begin
      m_st = 2'd1;
    end else begin
      nc = (noop || flush || !m_v) ? 8'h0 : cid;
      if (stall) begin
        m_st = 2'd2;
        if (m_cnt < MAXS + 1) m_cnt++;
      end else begin
        m_st = 2'd1; m_cnt = 0;
        if (flush) begin
          m_pc = tgt; m_instr = 32'h13; m_ipc = 32'h0; m_v = 1'b0;
        end else begin
          m_instr = 32'hA0 + m_pc; m_ipc = m_pc; m_pc = m_pc + 32'd4; m_v = 1'b1;
        end
      end
      m_ctrl = nc;
      if (m_cnt > MAXS) m_err = 1'b1;
    end
    sb_q.push_back('{pc: m_pc, instr: m_instr, ipc: m_ipc, v: m_v, ctrl: m_ctrl, st: m_st, err: m_err});
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset();
    drive_cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 8'h0);
    exp_o = sb_q.pop_front(); got_o = sample(); n_cmp++;
    if (got_o !== exp_o) begin n_bad++; $display("FAIL reset_model got=%h exp=%h", got_o, exp_o); end
    n_cmp++;
    if (got_o !== obs_t'({32'h0, 32'h13, 32'h0, 1'b0, 8'h0, 2'd0, 1'b0})) begin
      n_bad++; $display("FAIL reset_values got=%h", got_o);
    end
    drive_cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 8'h11);
    exp_o = sb_q.pop_front(); got_o = sample(); n_cmp++;
    if (got_o !== exp_o || bus.state_o !== 2'd0 || bus.pc_o !== 32'h0) begin
      n_bad++; $display("FAIL idle_hold got=%h exp=%h", got_o, exp_o);
    end
  endtask

  task automatic test_run();
    for (int k = 1; k <= 5; k++) begin
      drive_cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 8'(k * 17));
      exp_o = sb_q.pop_front(); got_o = sample(); n_cmp++;
      if (got_o !== exp_o) begin n_bad++; $display("FAIL run_model k=%0d got=%h exp=%h", k, got_o, exp_o); end
      n_cmp++;
      if (bus.pc_o !== 32'(4 * (k - 1)) || bus.ifid_valid_o !== (k >= 2)) begin
        n_bad++; $display("FAIL run_pc k=%0d pc=%h valid=%b", k, bus.pc_o, bus.ifid_valid_o);
      end
    end
  endtask

  task automatic test_load_use();
    drive_cycle(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 8'hFF);
    exp_o = sb_q.pop_front(); got_o = sample(); n_cmp++;
    if (got_o !== exp_o) begin n_bad++; $display("FAIL lu_model got=%h exp=%h", got_o, exp_o); end
    n_cmp++;
    if (bus.pc_o !== 32'h10 || bus.ifid_pc_o !== 32'hC || bus.ctrl_ex_o !== 8'h0 || bus.state_o !== 2'd2) begin
      n_bad++; $display("FAIL lu_hold pc=%h ipc=%h ctrl=%h st=%0d", bus.pc_o, bus.ifid_pc_o, bus.ctrl_ex_o, bus.state_o);
    end
    drive_cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 8'h3C);
    exp_o = sb_q.pop_front(); got_o = sample(); n_cmp++;
    if (got_o !== exp_o || bus.state_o !== 2'd1 || bus.pc_o !== 32'h14) begin
      n_bad++; $display("FAIL lu_resume got=%h exp=%h", got_o, exp_o);
    end
  endtask

  task automatic test_branch();
    drive_cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 8'h21);
    exp_o = sb_q.pop_front(); got_o = sample(); n_cmp++;
    if (got_o !== exp_o || bus.pc_o !== 32'h18) begin n_bad++; $display("FAIL br_pre got=%h exp=%h", got_o, exp_o); end
    drive_cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h40, 8'h77);
    exp_o = sb_q.pop_front(); got_o = sample(); n_cmp++;
    if (got_o !== exp_o) begin n_bad++; $display("FAIL br_model got=%h exp=%h", got_o, exp_o); end
    n_cmp++;
    if (bus.pc_o !== 32'h40 || bus.ifid_instr_o !== 32'h13 || bus.ifid_valid_o !== 1'b0) begin
      n_bad++; $display("FAIL br_flush pc=%h instr=%h v=%b", bus.pc_o, bus.ifid_instr_o, bus.ifid_valid_o);
    end
    drive_cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 8'h77);
    exp_o = sb_q.pop_front(); got_o = sample(); n_cmp++;
    if (got_o !== exp_o || bus.ctrl_ex_o !== 8'h0) begin
      n_bad++; $display("FAIL br_ctrl got=%h exp=%h", got_o, exp_o);
    end
  endtask

  task automatic test_flush_in_stall();
    drive_cycle(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 32'h80, 8'h5A);
    exp_o = sb_q.pop_front(); got_o = sample(); n_cmp++;
    if (got_o !== exp_o || bus.pc_o !== 32'h44 || bus.ifid_pc_o !== 32'h40 || bus.ifid_valid_o !== 1'b1) begin
      n_bad++; $display("FAIL fs_ignored got=%h exp=%h", got_o, exp_o);
    end
    drive_cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h80, 8'h5A);
    exp_o = sb_q.pop_front(); got_o = sample(); n_cmp++;
    if (got_o !== exp_o || bus.pc_o !== 32'h80 || bus.ifid_valid_o !== 1'b0) begin
      n_bad++; $display("FAIL fs_taken got=%h exp=%h", got_o, exp_o);
    end
  endtask

  task automatic test_stall_err();
    logic [4:0] st_tab;
    logic [4:0] err_tab;
    st_tab  = 5'b00111;
    err_tab = 5'b11100;
    for (int k = 0; k < 5; k++) begin
      drive_cycle(1'b1, 1'b1, st_tab[k], st_tab[k], 1'b0, 32'h0, 8'h42);
      exp_o = sb_q.pop_front(); got_o = sample(); n_cmp++;
      if (got_o !== exp_o) begin n_bad++; $display("FAIL serr_model k=%0d got=%h exp=%h", k, got_o, exp_o); end
      n_cmp++;
      if (bus.stall_err_o !== err_tab[k]) begin
        n_bad++; $display("FAIL serr_flag k=%0d got=%b exp=%b", k, bus.stall_err_o, err_tab[k]);
      end
    end
  endtask

  task automatic test_reset_mid_stall();
    drive_cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h20, 8'h0);
    void'(sb_q.pop_front());
    drive_cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 8'h9);
    void'(sb_q.pop_front());
    drive_cycle(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 8'h9);
    exp_o = sb_q.pop_front(); got_o = sample(); n_cmp++;
    if (got_o !== exp_o || bus.pc_o !== 32'h24 || bus.state_o !== 2'd2) begin
      n_bad++; $display("FAIL rms_pre got=%h exp=%h", got_o, exp_o);
    end
    drive_cycle(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 32'h100, 8'h9);
    exp_o = sb_q.pop_front(); got_o = sample(); n_cmp++;
    if (got_o !== exp_o || bus.pc_o !== 32'h0 || bus.state_o !== 2'd0 || bus.ifid_valid_o !== 1'b0 ||
        bus.ctrl_ex_o !== 8'h0 || bus.stall_err_o !== 1'b0) begin
      n_bad++; $display("FAIL rms_reset got=%h exp=%h", got_o, exp_o);
    end
  endtask

  task automatic test_idle();
    logic [5:0] start_tab;
    start_tab = 6'b110011;
    for (int k = 0; k < 6; k++) begin
      drive_cycle(1'b1, start_tab[k], 1'b0, 1'b0, 1'b0, 32'h0, 8'(k + 1));
      exp_o = sb_q.pop_front(); got_o = sample(); n_cmp++;
      if (got_o !== exp_o) begin n_bad++; $display("FAIL idle_model k=%0d got=%h exp=%h", k, got_o, exp_o); end
    end
    n_cmp++;
    if (bus.pc_o !== 32'h8) begin n_bad++; $display("FAIL idle_pc got=%h exp=%h", bus.pc_o, 32'h8); end
  endtask

  task automatic test_wrap();
    drive_cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC, 8'h0);
    void'(sb_q.pop_front());
    drive_cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 8'h0);
    exp_o = sb_q.pop_front(); got_o = sample(); n_cmp++;
    if (got_o !== exp_o || bus.pc_o !== 32'h0 || bus.ifid_pc_o !== 32'hFFFF_FFFC) begin
      n_bad++; $display("FAIL wrap got=%h exp=%h", got_o, exp_o);
    end
  endtask

  task automatic test_random();
    logic st;
    for (int k = 0; k < 300; k++) begin
      st = ($urandom_range(0, 3) == 0);
      drive_cycle(1'b1, ($urandom_range(0, 19) != 0), st, st | ($urandom_range(0, 7) == 0),
                  ($urandom_range(0, 7) == 0), 32'($urandom) & 32'hFFFF_FFFC, 8'($urandom));
      exp_o = sb_q.pop_front(); got_o = sample(); n_cmp++;
      if (got_o !== exp_o) begin n_bad++; $display("FAIL rand k=%0d got=%h exp=%h", k, got_o, exp_o); end
    end
  endtask

  initial begin
    test_reset();
    test_run();
    test_load_use();
    test_branch();
    test_flush_in_stall();
    test_stall_err();
    test_reset_mid_stall();
    test_idle();
    test_wrap();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
